// File: rtl/niosduino_spi_slave_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : niosduino_spi_slave_pkg
//  Description : Shared constants and types for the NIOSDuino SPI slave.
//                Register addresses, status/control bit positions and the
//                transfer state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package niosduino_spi_slave_pkg;

    // Avalon register addresses
    localparam logic [2:0] ADDR_RXDATA  = 3'd0;
    localparam logic [2:0] ADDR_TXDATA  = 3'd1;
    localparam logic [2:0] ADDR_STATUS  = 3'd2;
    localparam logic [2:0] ADDR_CONTROL = 3'd3;
    localparam logic [2:0] ADDR_EOPVAL  = 3'd6;

    // Status bit positions (interrupt enables share the same positions)
    localparam int EOP  = 9;
    localparam int E    = 8;
    localparam int RRDY = 7;
    localparam int TRDY = 6;
    localparam int TMT  = 5;
    localparam int TOE  = 4;
    localparam int ROE  = 3;

    // Writable interrupt-enable bits: 9,8,7,6,4,3 (TMT enable reads 0)
    localparam logic [15:0] C_CTRL_MASK = 16'h03D8;

    // Transfer state
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_e;

endpackage
`default_nettype wire

// File: rtl/niosduino_spi_slave_sync.sv
`default_nettype none
// ============================================================================
//  Module      : niosduino_spi_slave_sync
//  Description : Multi-stage synchroniser for one asynchronous SPI pin plus a
//                single-cycle rise/fall edge detector on the synchronised level.
//  Ports       : clk, reset_n       - system clock, async active-low reset
//                async_in           - raw pin
//                sync_out           - synchronised level
//                rise / fall        - one-clk pulses on synchronised edges
//  Revision    : 1.0  initial release
// ============================================================================
module niosduino_spi_slave_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic async_in,
    output logic sync_out,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] r_chain;
    logic                   r_prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_chain <= {SYNC_STAGES{RESET_VAL}};
            r_prev  <= RESET_VAL;
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], async_in};
            r_prev  <= r_chain[SYNC_STAGES-1];
        end
    end

    assign sync_out = r_chain[SYNC_STAGES-1];
    assign rise     =  r_chain[SYNC_STAGES-1] & ~r_prev;
    assign fall     = ~r_chain[SYNC_STAGES-1] &  r_prev;

endmodule
`default_nettype wire

// File: rtl/niosduino_spi_slave.sv
`default_nettype none
// ============================================================================
//  Module      : niosduino_spi_slave
//  Description : SPI slave (mode 0, 8-bit frames, single select) with the
//                NIOSDuino Avalon register map shared with the SPI master.
//                SPI pins are synchronised to clk; SCLK must be <= clk/8.
//  Build macro : NIOSDUINO_SPI_SLAVE_LSBFIRST_EN - when defined, frames are
//                shifted LSB-first instead of MSB-first.
//  Ports       : clk, reset_n                 - clock, async active-low reset
//                data_from_cpu, mem_addr      - Avalon write data / address
//                read_n, write_n, spi_select  - Avalon strobes / select
//                data_to_cpu, irq             - registered read data / irq
//                dataavailable, readyfordata,
//                endofpacket                  - RRDY, TRDY, EOP
//                SCLK, SS_n, MOSI, MISO       - SPI pins
//  Revision    : 1.0  initial release
// ============================================================================
module niosduino_spi_slave
    import niosduino_spi_slave_pkg::*;
#(
    parameter int DATABITS    = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] data_from_cpu,
    input  logic [2:0]  mem_addr,
    input  logic        read_n,
    input  logic        write_n,
    input  logic        spi_select,
    output logic [15:0] data_to_cpu,
    output logic        irq,
    output logic        dataavailable,
    output logic        readyfordata,
    output logic        endofpacket,
    input  logic        SCLK,
    input  logic        SS_n,
    input  logic        MOSI,
    output logic        MISO
);

    // ------------------------------------------------------------------
    // Pin synchronisers
    // ------------------------------------------------------------------
    logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
    logic w_ss_lvl,   w_ss_rise,   w_ss_fall;
    logic w_mosi_lvl, w_mosi_rise, w_mosi_fall;
    logic w_unused;

    niosduino_spi_slave_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .reset_n(reset_n), .async_in(SCLK),
        .sync_out(w_sclk_lvl), .rise(w_sclk_rise), .fall(w_sclk_fall)
    );

    // SS_n resets to the asserted level: if reset is released while the
    // master holds SS_n low, no falling edge is seen and that frame is
    // ignored until SS_n rises and falls again.
    niosduino_spi_slave_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_ss (
        .clk(clk), .reset_n(reset_n), .async_in(SS_n),
        .sync_out(w_ss_lvl), .rise(w_ss_rise), .fall(w_ss_fall)
    );

    niosduino_spi_slave_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .reset_n(reset_n), .async_in(MOSI),
        .sync_out(w_mosi_lvl), .rise(w_mosi_rise), .fall(w_mosi_fall)
    );

    assign w_unused = &{1'b0, w_sclk_lvl, w_ss_lvl, w_mosi_rise, w_mosi_fall};

    // ------------------------------------------------------------------
    // Avalon two-cycle strobes: pulse on the first qualified cycle, act on
    // the second, then drop so a held strobe does not act twice.
    // ------------------------------------------------------------------
    logic r_wr_strobe, r_rd_strobe;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_strobe <= 1'b0;
            r_rd_strobe <= 1'b0;
        end else begin
            r_wr_strobe <= r_wr_strobe ? 1'b0 : (spi_select & ~write_n);
            r_rd_strobe <= r_rd_strobe ? 1'b0 : (spi_select & ~read_n);
        end
    end

    logic w_wr_tx, w_wr_status, w_wr_ctrl, w_wr_eopval, w_rd_rx;

    assign w_wr_tx     = r_wr_strobe & (mem_addr == ADDR_TXDATA);
    assign w_wr_status = r_wr_strobe & (mem_addr == ADDR_STATUS);
    assign w_wr_ctrl   = r_wr_strobe & (mem_addr == ADDR_CONTROL);
    assign w_wr_eopval = r_wr_strobe & (mem_addr == ADDR_EOPVAL);
    assign w_rd_rx     = r_rd_strobe & (mem_addr == ADDR_RXDATA);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    spi_state_e          r_state;
    logic [2:0]          r_bitcnt;
    logic [DATABITS-1:0] r_shift;
    logic                r_rx_bit;
    logic                r_reload;
    logic                r_miso;
    logic [DATABITS-1:0] r_rx_holding;
    logic [DATABITS-1:0] r_tx_holding;
    logic                r_tx_primed;
    logic                r_rrdy, r_roe, r_toe, r_eop;
    logic [15:0]         r_ctrl;
    logic [15:0]         r_eopval;

    // ------------------------------------------------------------------
    // Shift-direction dependent datapath
    // ------------------------------------------------------------------
    logic [DATABITS-1:0] w_shift_in;
    logic [DATABITS-1:0] w_rx_byte;
    logic                w_miso_bit;

`ifdef NIOSDUINO_SPI_SLAVE_LSBFIRST_EN
    assign w_shift_in = {r_rx_bit, r_shift[DATABITS-1:1]};
    assign w_rx_byte  = {w_mosi_lvl, r_shift[DATABITS-1:1]};
    assign w_miso_bit = r_shift[0];
`else
    assign w_shift_in = {r_shift[DATABITS-2:0], r_rx_bit};
    assign w_rx_byte  = {r_shift[DATABITS-2:0], w_mosi_lvl};
    assign w_miso_bit = r_shift[DATABITS-1];
`endif

    // A load happens on the SS_n falling edge or on the SCLK falling edge
    // that follows a completed byte (back-to-back frames).
    logic                w_load;
    logic [DATABITS-1:0] w_load_data;
    logic                w_byte_done;
    logic                w_tx_free;
    logic                w_trdy, w_tmt;

    assign w_load = ~w_ss_rise &
                    (((r_state == IDLE)   & w_ss_fall) |
                     ((r_state == ACTIVE) & w_sclk_fall & r_reload));

    // Underrun simply sends zeros.
    assign w_load_data = r_tx_primed ? r_tx_holding : '0;

    assign w_byte_done = (r_state == ACTIVE) & ~w_ss_rise & w_sclk_rise &
                         (r_bitcnt == 3'(DATABITS - 1));

    // The holding register is free for a CPU write if it is empty, or if it
    // is being moved into the shifter this very cycle.
    assign w_tx_free = ~r_tx_primed | w_load;

    assign w_trdy = ~r_tx_primed;
    assign w_tmt  = ~r_tx_primed & (r_state != ACTIVE);

    // ------------------------------------------------------------------
    // Transfer state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_bitcnt <= 3'd0;
            r_shift  <= '0;
            r_rx_bit <= 1'b0;
            r_reload <= 1'b0;
            r_miso   <= 1'b0;
        end else begin
            r_miso <= (r_state == ACTIVE) ? w_miso_bit : 1'b0;

            if (w_ss_rise) begin
                // Deselect drops any partial byte.
                r_state  <= IDLE;
                r_bitcnt <= 3'd0;
                r_reload <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_bitcnt <= 3'd0;
                        r_reload <= 1'b0;
                        if (w_ss_fall) begin
                            r_state <= ACTIVE;
                            r_shift <= w_load_data;
                        end
                    end
                    ACTIVE: begin
                        if (w_sclk_rise) begin
                            r_rx_bit <= w_mosi_lvl;
                            if (w_byte_done) begin
                                r_bitcnt <= 3'd0;
                                r_reload <= 1'b1;
                            end else begin
                                r_bitcnt <= r_bitcnt + 3'd1;
                            end
                        end
                        if (w_sclk_fall) begin
                            if (r_reload) begin
                                r_shift  <= w_load_data;
                                r_reload <= 1'b0;
                            end else begin
                                r_shift <= w_shift_in;
                            end
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Holding registers, status flags and configuration
    // Later assignments win, so flag sets override same-cycle clears.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_holding <= '0;
            r_tx_holding <= '0;
            r_tx_primed  <= 1'b0;
            r_rrdy       <= 1'b0;
            r_roe        <= 1'b0;
            r_toe        <= 1'b0;
            r_eop        <= 1'b0;
            r_ctrl       <= 16'h0000;
            r_eopval     <= 16'h0000;
        end else begin
            if (w_wr_status) begin
                r_eop  <= 1'b0;
                r_rrdy <= 1'b0;
                r_roe  <= 1'b0;
                r_toe  <= 1'b0;
            end

            if (w_rd_rx) begin
                r_rrdy <= 1'b0;
                if (r_rx_holding == r_eopval[DATABITS-1:0]) begin
                    r_eop <= 1'b1;
                end
            end

            if (w_byte_done) begin
                r_rx_holding <= w_rx_byte;
                r_rrdy       <= 1'b1;
                if (r_rrdy) begin
                    r_roe <= 1'b1;
                end
            end

            if (w_load && r_tx_primed) begin
                r_tx_primed <= 1'b0;
            end

            if (w_wr_tx) begin
                if (w_tx_free) begin
                    r_tx_holding <= data_from_cpu[DATABITS-1:0];
                    r_tx_primed  <= 1'b1;
                end else begin
                    r_toe <= 1'b1;
                end
                if (data_from_cpu[DATABITS-1:0] == r_eopval[DATABITS-1:0]) begin
                    r_eop <= 1'b1;
                end
            end

            if (w_wr_ctrl) begin
                r_ctrl <= data_from_cpu & C_CTRL_MASK;
            end

            if (w_wr_eopval) begin
                r_eopval <= data_from_cpu;
            end
        end
    end

    // ------------------------------------------------------------------
    // Status word and read mux
    // ------------------------------------------------------------------
    logic [15:0] w_status;
    logic [15:0] w_rd_data;

    always_comb begin
        w_status       = 16'h0000;
        w_status[EOP]  = r_eop;
        w_status[E]    = r_roe | r_toe;
        w_status[RRDY] = r_rrdy;
        w_status[TRDY] = w_trdy;
        w_status[TMT]  = w_tmt;
        w_status[TOE]  = r_toe;
        w_status[ROE]  = r_roe;
    end

    always_comb begin
        w_rd_data = 16'h0000;
        case (mem_addr)
            ADDR_RXDATA:  w_rd_data = 16'(r_rx_holding);
            ADDR_STATUS:  w_rd_data = w_status;
            ADDR_CONTROL: w_rd_data = r_ctrl;
            ADDR_EOPVAL:  w_rd_data = r_eopval;
            default:      w_rd_data = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_to_cpu <= 16'h0000;
            irq         <= 1'b0;
        end else begin
            data_to_cpu <= w_rd_data;
            irq         <= |(w_status & r_ctrl);
        end
    end

    assign dataavailable = r_rrdy;
    assign readyfordata  = w_trdy;
    assign endofpacket   = r_eop;
    assign MISO          = r_miso;

endmodule
`default_nettype wire

// File: doc/niosduino_spi_slave.md
Name: niosduino_spi_slave

Overview:
- SPI slave (target) peripheral for the NIOSDuino core, the responder end of the Avalon-mapped SPI master.
- Mode 0 (CPOL=0, CPHA=0), MSB-first, 8-bit frames, single slave-select.
- CPU side uses the same Avalon register map, status/control bit layout, two-cycle access and IRQ scheme as the master, so the same driver code applies.
- SPI pins are asynchronous to clk. They are synchronised and edge-detected internally, which limits SCLK to at most clk/8.

Parameters:
- DATABITS, 8, frame width in bits (only 8 is supported).
- SYNC_STAGES, 2, flip-flop stages on SCLK, SS_n and MOSI (minimum 2).

Ports:
- clk  in  1  system clock, 50 MHz.
- reset_n  in  1  asynchronous, active-low reset.
- data_from_cpu  in  16  Avalon write data.
- mem_addr  in  3  register address.
- read_n  in  1  Avalon read, active low.
- write_n  in  1  Avalon write, active low.
- spi_select  in  1  chip select from the Avalon fabric.
- data_to_cpu  out  16  registered read data.
- irq  out  1  registered interrupt.
- dataavailable  out  1  equals RRDY.
- readyfordata  out  1  equals TRDY.
- endofpacket  out  1  equals EOP.
- SCLK  in  1  SPI clock from the master.
- SS_n  in  1  slave select, active low.
- MOSI  in  1  master-out data.
- MISO  out  1  slave-out data.

Behaviour:
- Register map:
  - 0: rx data (r).
  - 1: tx data (w).
  - 2: status (r; any write clears EOP, RRDY, ROE, TOE).
  - 3: control (r/w).
  - 6: end-of-packet value (r/w).
  - 4 and 5 read 0 and ignore writes.
- Status layout: [9] EOP, [8] E=ROE|TOE, [7] RRDY, [6] TRDY, [5] TMT, [4] TOE, [3] ROE. All other bits are 0.
- Control layout: [9:3] interrupt enables in the same bit positions as status; [5] reads 0.
- Bus timing:
  - Reads and writes are two-cycle: the strobe is registered on the first qualified cycle and acts on the second.
  - data_to_cpu is registered (1-cycle latency).
  - irq is registered: OR of (status bit & enable).
- Synchroniser:
  - SCLK, SS_n and MOSI each pass through SYNC_STAGES flops.
  - One further flop per signal provides edge detection.
  - Events produced: sclk_rise, sclk_fall, ss_fall, ss_rise.
- State machine, IDLE -> ACTIVE:
  - IDLE: bitcnt=0; MISO=0.
  - ss_fall: go to ACTIVE and load the shift register.
    - If tx_holding_primed: load tx_holding_reg and clear primed.
    - Otherwise: load 8'h00 (underrun; no flag).
  - ACTIVE: MISO = shift_reg[7].
    - sclk_rise: sample MOSI into rx_bit; bitcnt+1.
    - sclk_fall: shift_reg <= {shift_reg[6:0], rx_bit}.
  - Byte complete, on the 8th sclk_rise:
    - rx_holding_reg <= {shift_reg[6:0], MOSI_sync}.
    - RRDY <= 1; ROE <= 1 if RRDY was already set.
    - bitcnt <= 0.
    - The next sclk_fall reloads the shift register from tx_holding (or 0) for a back-to-back byte.
  - ss_rise in any state: return to IDLE, drop the partial byte, reset bitcnt, leave RRDY unchanged.
- TRDY = ~tx_holding_primed.
- TMT = ~tx_holding_primed & ~ACTIVE.
- Writing addr 1 while TRDY=0 sets TOE and discards the data.
- EOP is set when either of these matches endofpacketvalue_reg[7:0]:
  - an addr-0 read of rx_holding_reg;
  - addr-1 write data bits [7:0].
- Simultaneous events:
  - Status-write clear and a new byte completion in the same cycle: the set wins.
  - An addr-1 write in the same cycle as a shift-register load: the old holding value is loaded and the new value becomes primed.
- Reset mid-transfer: everything returns to reset values. The first byte after reset uses a fresh ss_fall; frames already in progress are ignored until SS_n rises.
- Reset values: data_to_cpu=0, irq=0, MISO=0, all status bits 0 except TRDY=1 and TMT=1, all enables 0, endofpacketvalue=0.

Optional Feature:
- NIOSDUINO_SPI_SLAVE_LSBFIRST_EN.
- When defined: shift direction is reversed. MISO = shift_reg[0], shifting is right, received bits enter at [7].
- When undefined: MSB-first as above.
- The register map is identical in both builds.

Decomposition:
- Package niosduino_spi_slave_pkg holds:
  - register address constants (ADDR_RXDATA=0, ADDR_TXDATA=1, ADDR_STATUS=2, ADDR_CONTROL=3, ADDR_EOPVAL=6);
  - status bit index constants (EOP=9 ... ROE=3);
  - the state enum {IDLE, ACTIVE}.
- Sub-module niosduino_spi_slave_sync: a parameterised multi-stage synchroniser plus rise/fall edge detector, instantiated once per SPI input.

Test Plan:
- Write 0xA5 to addr 1, then master sends 0x3C at clk/16 -> MISO shifts out 1010_0101; read addr 0 returns 0x003C; status bit 7 is set before the read and clear after.
- Two back-to-back bytes 0x11, 0x22 with no CPU read -> ROE=1, E=1, rx=0x22; a write to addr 2 clears ROE, E and RRDY.
- Write 0x55, then write 0x66 before SS_n falls -> TOE=1; MISO sends 0x55.
- SS_n rises after 4 bits -> RRDY stays 0, bitcnt resets; the next full frame 0x81 is received as 0x81.
- Enable RRDY IRQ (control=0x0080), send one byte -> irq goes high within 2 clk of the 8th sclk_rise; an addr-0 read drops irq.
- Set EOP value 0x0D and receive 0x0D -> reading addr 0 sets EOP; with control bit 9 set, irq is asserted.
